// File: rtl/ride_mode_controller.sv
// ride_mode_controller
//   Top-level mode sequencer for a bike-computer display. Raw buttons and the
//   wheel sensor are synchronised and debounced. A HOME/RIDE/PAUSED/SUMMARY
//   state machine is driven from their rising-edge events. The page shown on
//   the VGA display only changes at a vertical-sync falling edge, so a frame
//   is never drawn half in one page and half in another.
//
// Ports
//   clk          in   system clock (only clock)
//   reset        in   synchronous, active-low reset
//   start_btn    in   raw start/resume button, high = pressed (asynchronous)
//   stop_btn     in   raw stop button, high = pressed (asynchronous)
//   revolution   in   raw wheel sensor, high = magnet present (asynchronous)
//   vsync        in   clk-domain vertical sync, active-low pulse
//   page_sel     out  page to render: 0 HOME, 1 RIDE, 2 PAUSED, 3 SUMMARY
//   counter_clr  out  one-cycle clear to the ride statistics counter
//   counter_en   out  time-accumulation enable, high while in RIDE
//   rev_pulse    out  one-cycle debounced, gated revolution event
//   dbg_state    out  current state register, for observation only
//
// Handshake note: there is no valid/ready traffic here. Every event is a
// single-cycle pulse. It is consumed in the cycle it is high, and nothing
// acknowledges it.

module ride_mode_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int IDLE_TIMEOUT    = 300000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       stop_btn,
    input  logic       revolution,
    input  logic       vsync,
    output logic [1:0] page_sel,
    output logic       counter_clr,
    output logic       counter_en,
    output logic       rev_pulse,
    output logic [1:0] dbg_state
);

    // Input lanes: 0 = start, 1 = stop, 2 = revolution.
    localparam int NUM_IN = 3;

    // The debounce counter only needs to reach DEBOUNCE_CYCLES-1.
    localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  DB_MAX    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_SAT  = IDLE_W'(IDLE_TIMEOUT);

    typedef enum logic [1:0] {
        HOME    = 2'd0,
        RIDE    = 2'd1,
        PAUSED  = 2'd2,
        SUMMARY = 2'd3
    } state_t;

    logic [NUM_IN-1:0]             raw_in;
    logic [NUM_IN-1:0]             sync1_q, sync1_d;
    logic [NUM_IN-1:0]             sync2_q, sync2_d;
    logic [NUM_IN-1:0]             level_q, level_d;
    logic [NUM_IN-1:0]             evt_q, evt_d;
    logic [NUM_IN-1:0][CNT_W-1:0]  db_cnt_q, db_cnt_d;

    state_t                        state_q, state_d;
    logic [IDLE_W-1:0]             idle_q, idle_d;
    logic                          clr_q, clr_d;
    logic                          rev_pulse_q, rev_pulse_d;
    logic [1:0]                    page_q, page_d;
    logic                          vsync_prev_q, vsync_prev_d;

    logic                          start_evt, stop_evt, rev_evt;

    assign raw_in    = {revolution, stop_btn, start_btn};
    assign start_evt = evt_q[0];
    assign stop_evt  = evt_q[1];
    assign rev_evt   = evt_q[2];

    // Synchronise and debounce each input.
    // The accepted level flips only after the synchronised value has
    // disagreed with it on DEBOUNCE_CYCLES consecutive clocks. One agreeing
    // clock restarts the count.
    always_comb begin
        sync1_d  = raw_in;
        sync2_d  = sync1_q;
        level_d  = level_q;
        evt_d    = '0;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sync2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_MAX) begin
                    level_d[i]  = sync2_q[i];
                    db_cnt_d[i] = '0;
                    // Only the rising edge of the accepted level is an event.
                    evt_d[i]    = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end else begin
                db_cnt_d[i] = '0;
            end
        end
    end

    // Next state, the registered pulse outputs, and the idle counter.
    always_comb begin
        state_d     = state_q;
        clr_d       = 1'b0;
        rev_pulse_d = 1'b0;
        idle_d      = idle_q;

        case (state_q)
            HOME: begin
                // Stop has no meaning here and is ignored.
                if (start_evt) begin
                    state_d = RIDE;
                    clr_d   = 1'b1;
                end
            end
            RIDE: begin
                rev_pulse_d = rev_evt;
                if (stop_evt) begin
                    state_d = SUMMARY;
                end else if (!rev_evt && idle_q == IDLE_LAST) begin
                    // A revolution in the final idle clock counts as activity.
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                // Stop wins over start or revolution. A revolution that
                // resumes the ride is passed on as a pulse.
                if (stop_evt) begin
                    state_d = SUMMARY;
                end else if (start_evt || rev_evt) begin
                    state_d     = RIDE;
                    rev_pulse_d = rev_evt;
                end
            end
            SUMMARY: begin
                if (start_evt) begin
                    state_d = HOME;
                end
            end
            default: state_d = HOME;
        endcase

        if (state_q == RIDE && idle_q != IDLE_SAT) begin
            idle_d = idle_q + 1'b1;
        end
        if (rev_evt || (state_d == RIDE && state_q != RIDE)) begin
            idle_d = '0;
        end
    end

    // The page register loads only in the cycle after vsync falls.
    always_comb begin
        page_d       = page_q;
        vsync_prev_d = vsync;
        if (vsync_prev_q && !vsync) begin
            page_d = state_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            level_q      <= '0;
            evt_q        <= '0;
            db_cnt_q     <= '0;
            state_q      <= HOME;
            idle_q       <= '0;
            clr_q        <= 1'b0;
            rev_pulse_q  <= 1'b0;
            page_q       <= 2'd0;
            vsync_prev_q <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_q      <= level_d;
            evt_q        <= evt_d;
            db_cnt_q     <= db_cnt_d;
            state_q      <= state_d;
            idle_q       <= idle_d;
            clr_q        <= clr_d;
            rev_pulse_q  <= rev_pulse_d;
            page_q       <= page_d;
            vsync_prev_q <= vsync_prev_d;
        end
    end

    // counter_en is decoded straight from the state register.
    // It therefore tracks the state with no extra lag.
    assign counter_en  = (state_q == RIDE);
    assign counter_clr = clr_q;
    assign rev_pulse   = rev_pulse_q;
    assign page_sel    = page_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ride_mode_controller.sv
module tb_ride_mode_controller;

    localparam int DEB  = 4;
    localparam int IDLE = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_btn;
    logic       stop_btn;
    logic       revolution;
    logic       vsync;
    logic [1:0] page_sel;
    logic       counter_clr;
    logic       counter_en;
    logic       rev_pulse;
    logic [1:0] dbg_state;

    ride_mode_controller #(
        .DEBOUNCE_CYCLES (DEB),
        .IDLE_TIMEOUT    (IDLE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_btn   (start_btn),
        .stop_btn    (stop_btn),
        .revolution  (revolution),
        .vsync       (vsync),
        .page_sel    (page_sel),
        .counter_clr (counter_clr),
        .counter_en  (counter_en),
        .rev_pulse   (rev_pulse),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoring ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    int clr_seen;
    int rev_seen;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Modes: 0 home, 1 ride, 2 paused, 3 summary.
    // Each input is modelled as a two-deep delay line followed by a run-length
    // acceptance rule.
    logic [1:0] m_pipe [3];
    logic       m_acc  [3];
    int         m_run  [3];
    logic       m_ev   [3];
    logic [2:0] m_raw;
    int         m_mode, m_nxt, m_page, m_quiet;
    logic       m_clr, m_rp, m_vs_prev;

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                m_pipe[i] = 2'b00;
                m_acc[i]  = 1'b0;
                m_run[i]  = 0;
                m_ev[i]   = 1'b0;
            end
            m_mode = 0; m_page = 0; m_quiet = 0;
            m_clr = 1'b0; m_rp = 1'b0; m_vs_prev = 1'b0;
        end else begin
            // Page follows the mode seen at a vsync falling edge.
            if (m_vs_prev && !vsync) m_page = m_mode;
            m_vs_prev = vsync;

            // Mode rules, using the events from the previous step.
            m_nxt = m_mode;
            m_clr = 1'b0;
            m_rp  = 1'b0;
            case (m_mode)
                0: if (m_ev[0]) begin m_nxt = 1; m_clr = 1'b1; end
                1: begin
                    m_rp = m_ev[2];
                    if (m_ev[1]) m_nxt = 3;
                    else if (!m_ev[2] && m_quiet == IDLE - 1) m_nxt = 2;
                end
                2: begin
                    if (m_ev[1]) m_nxt = 3;
                    else if (m_ev[0] || m_ev[2]) begin m_nxt = 1; m_rp = m_ev[2]; end
                end
                default: if (m_ev[0]) m_nxt = 0;
            endcase
            // Quiet time: cycles spent riding since the ride began or the wheel last turned.
            if (m_ev[2] || (m_nxt == 1 && m_mode != 1)) m_quiet = 0;
            else if (m_mode == 1 && m_quiet < IDLE) m_quiet = m_quiet + 1;
            m_mode = m_nxt;

            // Debounce: accept a new level once it has persisted DEB clocks.
            m_raw = {revolution, stop_btn, start_btn};
            for (int i = 0; i < 3; i++) begin
                m_ev[i] = 1'b0;
                if (m_pipe[i][1] != m_acc[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DEB) begin
                        m_acc[i] = m_pipe[i][1];
                        m_run[i] = 0;
                        m_ev[i]  = m_acc[i];
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_pipe[i] = {m_pipe[i][0], m_raw[i]};
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("mon_state", int'(dbg_state), m_mode);
        check("mon_page",  int'(page_sel), m_page);
        check("mon_clr",   int'(counter_clr), int'(m_clr));
        check("mon_en",    int'(counter_en), (m_mode == 1) ? 1 : 0);
        check("mon_rev",   int'(rev_pulse), int'(m_rp));
    end

    // ---------------- drivers ----------------
    task automatic set_in(input logic s, input logic p, input logic r, input logic v);
        start_btn  = s;
        stop_btn   = p;
        revolution = r;
        vsync      = v;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            clr_seen += int'(counter_clr);
            rev_seen += int'(rev_pulse);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       start;
        logic       stop;
        logic       rev;
        logic       vs;
        int         cycles;
        logic [1:0] exp_state;
        logic       exp_en;
        logic [1:0] exp_page;
        int         exp_clr;
        int         exp_rev;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic s, input logic p, input logic r, input logic v,
                       input int n, input logic [1:0] st, input logic en,
                       input logic [1:0] pg, input int nclr, input int nrev);
        vec_t e;
        e.start = s; e.stop = p; e.rev = r; e.vs = v; e.cycles = n;
        e.exp_state = st; e.exp_en = en; e.exp_page = pg;
        e.exp_clr = nclr; e.exp_rev = nrev;
        tbl.push_back(e);
    endtask

    initial begin
        int   hold [3];
        logic val  [3];
        int   thr  [3];
        int   ph;

        // Reset for two clocks: vsync idle high, buttons released.
        reset = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        clr_seen = 0; rev_seen = 0;
        run_cycles(2);
        check("reset_state", int'(dbg_state), 0);
        check("reset_page",  int'(page_sel), 0);
        check("reset_clr",   int'(counter_clr), 0);
        check("reset_en",    int'(counter_en), 0);
        check("reset_rev",   int'(rev_pulse), 0);

        // Fields: start stop rev vsync | cycles | state en page | #clr #rev
        add(1,0,0,1,  8, 2'd1,1,2'd0, 1,0); // start held: one clear, enters RIDE
        add(0,0,0,0,  1, 2'd1,1,2'd1, 0,0); // vsync fall: RIDE page shown
        add(0,0,0,1,  2, 2'd1,1,2'd1, 0,0);
        add(0,0,0,1, 14, 2'd1,1,2'd1, 0,0);
        add(0,0,0,1,  1, 2'd1,1,2'd1, 0,0); // last idle clock still RIDE
        add(0,0,0,1,  1, 2'd2,0,2'd1, 0,0); // 20 idle clocks: PAUSED
        add(0,0,1,1,  6, 2'd2,0,2'd1, 0,0); // revolution 6 clocks, still debouncing
        add(0,0,0,1,  1, 2'd1,1,2'd1, 0,1); // resume with one rev_pulse
        add(0,0,0,1, 19, 2'd1,1,2'd1, 0,0); // idle count restarted at zero
        add(0,0,0,1,  1, 2'd2,0,2'd1, 0,0);
        add(1,1,0,1,  8, 2'd3,0,2'd1, 0,0); // start+stop in PAUSED: SUMMARY
        add(0,0,0,1,  8, 2'd3,0,2'd1, 0,0);
        add(0,0,1,1,  8, 2'd3,0,2'd1, 0,0); // revolution ignored in SUMMARY
        add(0,0,0,1,  6, 2'd3,0,2'd1, 0,0);
        add(1,0,0,1,  8, 2'd0,0,2'd1, 0,0); // start: HOME, no clear, page holds
        add(0,0,0,0,  1, 2'd0,0,2'd0, 0,0); // vsync fall: HOME page shown
        add(0,0,0,1,  6, 2'd0,0,2'd0, 0,0);
        add(0,0,1,1,  8, 2'd0,0,2'd0, 0,0); // revolution in HOME: no pulse
        add(0,0,0,1,  6, 2'd0,0,2'd0, 0,0);
        for (int k = 0; k < 10; k++)        // start bouncing every 2 clocks
            add(logic'(k % 2 == 0),0,0,1, 2, 2'd0,0,2'd0, 0,0);
        add(0,0,0,1,  8, 2'd0,0,2'd0, 0,0);

        reset = 1'b1;
        foreach (tbl[k]) begin
            set_in(tbl[k].start, tbl[k].stop, tbl[k].rev, tbl[k].vs);
            clr_seen = 0; rev_seen = 0;
            run_cycles(tbl[k].cycles);
            check($sformatf("vec%0d_state", k), int'(dbg_state), int'(tbl[k].exp_state));
            check($sformatf("vec%0d_en", k),    int'(counter_en), int'(tbl[k].exp_en));
            check($sformatf("vec%0d_page", k),  int'(page_sel), int'(tbl[k].exp_page));
            check($sformatf("vec%0d_nclr", k),  clr_seen, tbl[k].exp_clr);
            check($sformatf("vec%0d_nrev", k),  rev_seen, tbl[k].exp_rev);
        end

        // Reset mid-ride while start stays held.
        set_in(1'b1, 1'b0, 1'b0, 1'b1);
        clr_seen = 0; rev_seen = 0;
        run_cycles(7);
        check("midride_state", int'(dbg_state), 1);
        check("midride_nclr",  clr_seen, 1);
        vsync = 1'b0;
        run_cycles(1);
        vsync = 1'b1;
        check("midride_page", int'(page_sel), 1);
        run_cycles(2);
        reset = 1'b0;
        clr_seen = 0;
        run_cycles(1);
        reset = 1'b1;
        check("rst_state", int'(dbg_state), 0);
        check("rst_page",  int'(page_sel), 0);
        check("rst_clr",   int'(counter_clr), 0);
        check("rst_en",    int'(counter_en), 0);
        check("rst_rev",   int'(rev_pulse), 0);
        run_cycles(6);
        check("held_wait_state", int'(dbg_state), 0);
        check("held_wait_nclr",  clr_seen, 0);
        run_cycles(1);
        check("held_fire_state", int'(dbg_state), 1);
        check("held_fire_clr",   int'(counter_clr), 1);

        // Randomised phase: the monitor compares every cycle against the model.
        thr[0] = 35; thr[1] = 12; thr[2] = 25;
        for (int i = 0; i < 3; i++) begin hold[i] = 0; val[i] = 1'b0; end
        ph = 1;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (hold[i] == 0) begin
                    val[i]  = ($urandom_range(0, 99) < thr[i]);
                    hold[i] = $urandom_range(1, 12);
                end
                hold[i]--;
            end
            set_in(val[0], val[1], val[2], logic'(ph != 0));
            ph = (ph + 1) % 17;
            reset = ($urandom_range(0, 799) != 0);
            run_cycles(1);
        end
        reset = 1'b1;
        run_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
